// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and width constants for the program loader
package loader_pkg;

  localparam int MAX_WORDS_DEFAULT = 128;
  localparam int WORD_W            = 32;
  localparam int BYTE_W            = 8;
  localparam int BYTES_PER_WORD    = WORD_W / BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, instruction-memory write port out
interface program_loader_if;
  import loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_byte;
  logic              in_ready;
  logic [63:0]       addr_ext;
  logic              wen_ext;
  logic              ren_ext;
  logic [WORD_W-1:0] wdata_ext;

  modport master (
    input  in_valid, in_byte,
    output in_ready, addr_ext, wen_ext, ren_ext, wdata_ext
  );

  modport slave (
    output in_valid, in_byte,
    input  in_ready, addr_ext, wen_ext, ren_ext, wdata_ext
  );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// rtl/program_loader_byte_assembler.sv - packs four little-endian bytes into one word
module byte_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_clear,
  input  logic              i_xfer,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_ready
);

  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word;

  // o_word already includes the byte in flight, so the word is usable on the 4th transfer
  always_comb begin
    w_word = r_word;
    w_word[{r_cnt, 3'b000} +: BYTE_W] = i_byte;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt  <= 2'd0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= 2'd0;
      r_word <= '0;
    end else if (i_xfer) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= w_word;
    end
  end

  assign o_word       = w_word;
  assign o_word_ready = i_xfer && (r_cnt == 2'd3) && !i_clear;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program image into instruction memory, then enables the CPU
module program_loader
  import loader_pkg::*;
#(
  parameter int          MAX_WORDS = MAX_WORDS_DEFAULT,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 start,
  input  logic [15:0]          word_count,
  input  logic                 abort,
  program_loader_if.master     bus,
  output logic                 cpu_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WORD_W-1:0]    checksum
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_index;
  logic [IDX_W-1:0]  r_count;
  logic [63:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_cksum;
  logic              r_wen;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_cpu_en;

  logic              w_xfer;
  logic              w_idle_like;
  logic              w_count_ok;
  logic              w_load;
  logic              w_clear;
  logic              w_last;
  logic [WORD_W-1:0] w_word;
  logic              w_word_ready;

  assign w_xfer      = bus.in_valid && r_in_ready;
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_count_ok  = (word_count != 16'd0) && (32'(word_count) <= 32'(MAX_WORDS));
  assign w_load      = !abort && start && w_idle_like && w_count_ok;
  assign w_clear     = abort || w_load;
  assign w_last      = (r_index == r_count - IDX_W'(1));

  byte_assembler u_asm (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_clear      (w_clear),
    .i_xfer       (w_xfer),
    .i_byte       (bus.in_byte),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) w_next = w_count_ok ? ST_RECV : ST_ERR;
        end
        ST_RECV:  if (w_word_ready) w_next = ST_WRITE;
        ST_WRITE: w_next = w_last ? ST_DONE : ST_RECV;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cksum    <= '0;
      r_wen      <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_en   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wen      <= (w_next == ST_WRITE);
      r_in_ready <= (w_next == ST_RECV);
      r_busy     <= (w_next == ST_RECV) || (w_next == ST_WRITE);
      r_done     <= (w_next == ST_DONE);
      r_err      <= (w_next == ST_ERR);
      r_cpu_en   <= (w_next == ST_DONE);

      if (w_load) begin
        r_index <= '0;
        r_count <= IDX_W'(word_count);
        r_cksum <= '0;
      end else if (r_state == ST_WRITE && !abort) begin
        r_cksum <= r_cksum + r_wdata;
        if (!w_last) r_index <= r_index + IDX_W'(1);
      end

      // Address and data are captured on entry to WRITE and then held until the next word
      if (w_next == ST_WRITE) begin
        r_addr  <= BASE_ADDR + 64'(r_index) * 64'(BYTES_PER_WORD);
        r_wdata <= w_word;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.addr_ext  = r_addr;
  assign bus.wen_ext   = r_wen;
  assign bus.ren_ext   = 1'b0;
  assign bus.wdata_ext = r_wdata;
  assign cpu_enable    = r_cpu_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_err;
  assign checksum      = r_cksum;

endmodule
